// File: rtl/head_sprite_fetch_if.sv
// Pixel-stream bundle between the VGA timing side, the sprite ROM and the
// palette stage of the head-sprite fetch pipeline.
interface head_sprite_fetch_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              pixel_en;
  logic              frame_start;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic [9:0]        head_x;
  logic [9:0]        head_y;
  logic [1:0]        head_dir;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_q;
  logic [3:0]        index_out;
  logic              hit_out;
  logic              blank_out;

  // Environment side: drives pixel stream, head state and ROM data
  modport master (
    output pixel_en, frame_start, DrawX, DrawY, blank,
    output head_x, head_y, head_dir, rom_q,
    input  rom_addr, index_out, hit_out, blank_out
  );

  // Fetch stage side
  modport slave (
    input  pixel_en, frame_start, DrawX, DrawY, blank,
    input  head_x, head_y, head_dir, rom_q,
    output rom_addr, index_out, hit_out, blank_out
  );
endinterface

// File: rtl/head_sprite_fetch.sv
// Head-sprite fetch stage: bounding-box test, sprite ROM addressing and
// registered palette index / hit flag, with head state shadowed per frame.
// Optional feature macro: HEAD_SPRITE_ROTATE_EN (direction-based sprite
// rotation; requires SPRITE_W == SPRITE_H). Undefined: mapping is always
// "down" and head_dir is ignored.
module head_sprite_fetch #(
  parameter int unsigned SPRITE_W        = 16,
  parameter int unsigned SPRITE_H        = 16,
  parameter int unsigned ADDR_W          = 8,
  parameter logic [3:0]  TRANSPARENT_IDX = 4'h2
) (
  input  logic               Clk,
  input  logic               Reset,
  head_sprite_fetch_if.slave bus
);

  localparam int unsigned CW = 11;   // signed coordinate difference width
  localparam int unsigned PW = 2 * CW;

  // Frame shadow registers
  logic [9:0] sx_q, sx_d;
  logic [9:0] sy_q, sy_d;
`ifdef HEAD_SPRITE_ROTATE_EN
  logic [1:0] sdir_q, sdir_d;
`else
  logic [1:0] unused_head_dir_c;
  assign unused_head_dir_c = bus.head_dir;
`endif

  // Pipeline registers
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              inbox_a_q, inbox_a_d;
  logic              blank_a_q, blank_a_d;
  logic [3:0]        index_q, index_d;
  logic              hit_q, hit_d;
  logic              blank_out_q, blank_out_d;

  // Stage A combinational terms
  logic [CW-1:0]     dx_c, dy_c;
  logic [CW-1:0]     row_c, col_c;
  logic              inbox_c;
  logic [ADDR_W-1:0] addr_c;

  // Box test and direction-mapped sprite address from shadowed head state
  always_comb begin
    dx_c    = {1'b0, bus.DrawX} - {1'b0, sx_q};
    dy_c    = {1'b0, bus.DrawY} - {1'b0, sy_q};
    inbox_c = ~dx_c[CW-1] & ~dy_c[CW-1]
            & (dx_c < CW'(SPRITE_W)) & (dy_c < CW'(SPRITE_H));
    row_c   = dy_c;
    col_c   = dx_c;
`ifdef HEAD_SPRITE_ROTATE_EN
    unique case (sdir_q)
      2'd1: begin
        row_c = CW'(SPRITE_H - 1) - dy_c;
        col_c = dx_c;
      end
      2'd2: begin
        row_c = dx_c;
        col_c = dy_c;
      end
      2'd3: begin
        row_c = CW'(SPRITE_W - 1) - dx_c;
        col_c = dy_c;
      end
      default: begin
        row_c = dy_c;
        col_c = dx_c;
      end
    endcase
`endif
    addr_c = '0;
    if (inbox_c) begin
      addr_c = ADDR_W'(PW'(row_c) * PW'(SPRITE_W) + PW'(col_c));
    end
  end

  // Next-state: shadow load on frame_start, pipeline advance on pixel_en
  always_comb begin
    sx_d        = sx_q;
    sy_d        = sy_q;
`ifdef HEAD_SPRITE_ROTATE_EN
    sdir_d      = sdir_q;
`endif
    rom_addr_d  = rom_addr_q;
    inbox_a_d   = inbox_a_q;
    blank_a_d   = blank_a_q;
    index_d     = index_q;
    hit_d       = hit_q;
    blank_out_d = blank_out_q;

    if (bus.frame_start) begin
      sx_d   = bus.head_x;
      sy_d   = bus.head_y;
`ifdef HEAD_SPRITE_ROTATE_EN
      sdir_d = bus.head_dir;
`endif
    end

    if (bus.pixel_en) begin
      rom_addr_d  = addr_c;
      inbox_a_d   = inbox_c;
      blank_a_d   = bus.blank;
      index_d     = bus.rom_q;
      hit_d       = inbox_a_q & blank_a_q & (bus.rom_q != TRANSPARENT_IDX);
      blank_out_d = blank_a_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sx_q        <= '0;
      sy_q        <= '0;
`ifdef HEAD_SPRITE_ROTATE_EN
      sdir_q      <= '0;
`endif
      rom_addr_q  <= '0;
      inbox_a_q   <= 1'b0;
      blank_a_q   <= 1'b0;
      index_q     <= '0;
      hit_q       <= 1'b0;
      blank_out_q <= 1'b0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
`ifdef HEAD_SPRITE_ROTATE_EN
      sdir_q      <= sdir_d;
`endif
      rom_addr_q  <= rom_addr_d;
      inbox_a_q   <= inbox_a_d;
      blank_a_q   <= blank_a_d;
      index_q     <= index_d;
      hit_q       <= hit_d;
      blank_out_q <= blank_out_d;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.index_out = index_q;
  assign bus.hit_out   = hit_q;
  assign bus.blank_out = blank_out_q;

endmodule

// File: doc/head_sprite_fetch.md
# head_sprite_fetch

Pixel-pipeline stage that sits directly upstream of a head-sprite palette lookup. For each pixel coordinate from the VGA controller, it:
- tests whether the pixel falls inside the snake head's bounding box;
- forms the sprite ROM address, applying a direction transform;
- registers the returned 4-bit palette index with a hit flag for the palette and colour mapper.

Head position and direction are shadowed at frame start so the sprite never tears mid-frame.

## Interface
Parameters:
- SPRITE_W, 16: sprite width in pixels.
- SPRITE_H, 16: sprite height in pixels. Must equal SPRITE_W when rotation is compiled in.
- ADDR_W, 8: ROM address width. Must satisfy 2^ADDR_W ≥ SPRITE_W·SPRITE_H.
- TRANSPARENT_IDX, 4'h2: palette index treated as transparent (magenta key).

Ports:
- Clk, in, 1: system clock (50 MHz).
- Reset, in, 1: synchronous, active-high.
- pixel_en, in, 1: pixel strobe (one Clk cycle in two). The pipeline advances only when it is high.
- frame_start, in, 1: one-Clk pulse at vertical retrace. Loads the shadow registers.
- DrawX, in, 10: current pixel column.
- DrawY, in, 10: current pixel row.
- blank, in, 1: high during the active display region.
- head_x, in, 10: live head top-left column.
- head_y, in, 10: live head top-left row.
- head_dir, in, 2: live direction. 0 = down, 1 = up, 2 = left, 3 = right.
- rom_addr, out, ADDR_W: address to the synchronous sprite ROM. The ROM has 1-Clk read latency.
- rom_q, in, 4: ROM data.
- index_out, out, 4: palette index for the palette stage.
- hit_out, out, 1: high when the pixel is inside the sprite and not transparent.
- blank_out, out, 1: `blank` delayed to align with `index_out`.

## Operation
- Shadow registers sx, sy, sdir load head_x, head_y, head_dir on any Clk where frame_start = 1, regardless of pixel_en. All address math uses only the shadow values.
- **Stage A** (on pixel_en):
  - dx = {1'b0,DrawX} − {1'b0,sx} and dy likewise, computed in 11-bit two's complement.
  - inbox = ~dx[10] & ~dy[10] & (dx < SPRITE_W) & (dy < SPRITE_H).
  - Map (dx, dy) to (row, col):
    - down: row = dy, col = dx.
    - up: row = SPRITE_H−1−dy, col = dx.
    - left: row = dx, col = dy.
    - right: row = SPRITE_W−1−dx, col = dy.
  - rom_addr ← row·SPRITE_W + col, truncated to ADDR_W.
  - When inbox = 0, rom_addr ← 0.
  - inbox_a ← inbox; blank_a ← blank.
- **ROM:** rom_q is valid from the Clk after rom_addr changes. It is stable until the next pixel_en because rom_addr holds.
- **Stage B** (on pixel_en):
  - index_out ← rom_q.
  - hit_out ← inbox_a & blank_a & (rom_q ≠ TRANSPARENT_IDX).
  - blank_out ← blank_a.
- Clipping:
  - A sprite partly beyond column 639 or row 479 clips naturally.
  - head_x ≥ 640 never produces a hit.

## Timing
- Reset values: rom_addr 0, index_out 0, hit_out 0, blank_out 0, inbox_a 0, blank_a 0, sx/sy 0, sdir 0.
- Latency: outputs reflect the DrawX/DrawY presented two pixel_en strobes earlier. Upstream sync signals must be delayed by 2 strobes to match.
- pixel_en low: all pipeline registers hold their values.
- frame_start and pixel_en high in the same Clk: Stage A uses the pre-update shadow values; the new values apply from the next strobe.
- Reset asserted mid-frame: pipeline clears on that Clk. hit_out stays 0 until at least 2 strobes after Reset falls.
- Reset and frame_start together: Reset wins.

## Configuration
- Macro `HEAD_SPRITE_ROTATE_EN`.
- Defined: direction mapping as in Operation. SPRITE_W = SPRITE_H is required.
- Undefined: head_dir and sdir are ignored, mapping is always "down", and non-square sprites are allowed. Per-direction sprites then come from separate ROMs selected downstream.

## Test plan
All scenarios use defaults and a 1-cycle ROM model returning a programmable value.

1. **Reset.** Assert Reset for 3 Clk with pixel_en toggling → rom_addr = 0, index_out = 0, hit_out = 0, blank_out = 0.
2. **Basic fetch.** head = (100,50), dir 0, pulse frame_start, blank = 1; present DrawX = 103, DrawY = 52 on one strobe → rom_addr = 0x23. ROM returns 5 → after the next strobe, index_out = 5 and hit_out = 1.
3. **Transparency.** Same coordinates, ROM returns 2 → index_out = 2, hit_out = 0. With blank = 0 and ROM = 5 → hit_out = 0, blank_out = 0.
4. **Bounds.** Sweep DrawX = 99, 100, 115, 116 at DrawY = 50 → hit_out = 0, 1, 1, 0. Separately, head_x = 630 with DrawX = 639 → hit with col = 9.
5. **Shadowing.** Change head_x to 200 without frame_start; DrawX = 103 still hits. After a frame_start pulse, DrawX = 103 → hit_out = 0 and DrawX = 203 → hit_out = 1.
6. **Rotation (macro defined).** dx = 3, dy = 2: dir 1 → rom_addr = 0xD3; dir 2 → 0x32; dir 3 → 0xC2. With the macro undefined, all directions → 0x23.
